// File: rtl/mips_run_checker.sv
// Core run-and-check sequencer: holds the core in reset, runs it, then compares its register file
// against an expected table. Defining MIPS_RUN_CHECKER_FAILMAP_EN adds the per-register fail_map output.
module mips_run_checker #(
    parameter int WIDTH      = 32,
    parameter int N_REGS     = 32,
    parameter int N_CYCLES   = 2000,
    parameter int RST_CYCLES = 10,
    localparam int AW        = (N_REGS > 1) ? $clog2(N_REGS) : 1,
    localparam int CW        = $clog2(N_REGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             core_rstb,
    output logic [AW-1:0]    rf_rd_addr,
    input  logic [WIDTH-1:0] rf_rd_data,
    output logic [AW-1:0]    exp_addr,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             exp_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    fail_count,
    output logic [AW-1:0]    first_fail
`ifdef MIPS_RUN_CHECKER_FAILMAP_EN
    ,
    output logic [N_REGS-1:0] fail_map
`endif
);

    localparam int TMAX = (N_CYCLES > RST_CYCLES) ? N_CYCLES : RST_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [AW-1:0] LAST_IDX  = AW'(N_REGS - 1);
    localparam logic [CW-1:0] MAX_FAILS = CW'(N_REGS);
    localparam logic [TW-1:0] HOLD_LAST = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] RUN_LAST  = TW'(N_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [TW-1:0]  cnt;
    logic [AW-1:0]  idx;
    logic           mismatch;
    logic           take_start;

    assign take_start = start && (state == S_IDLE || state == S_DONE);
    assign mismatch   = (state == S_CHECK) && exp_valid && (rf_rd_data != exp_data);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start)            state_next = S_HOLD;
            S_HOLD:  if (cnt == HOLD_LAST) state_next = S_RUN;
            S_RUN:   if (cnt == RUN_LAST)  state_next = S_CHECK;
            S_CHECK: if (idx == LAST_IDX)  state_next = S_DONE;
            S_DONE:  if (start)            state_next = S_IDLE;
            default:                       state_next = S_IDLE;
        endcase
    end

    always_comb begin
        core_rstb  = (state == S_RUN);
        busy       = (state == S_HOLD) || (state == S_RUN) || (state == S_CHECK);
        done       = (state == S_DONE);
        rf_rd_addr = idx;
        exp_addr   = idx;
    end

    // Phase timer restarts on every state change, so HOLD and RUN each count from zero.
    always_ff @(posedge clk) begin
        if (rst)                       cnt <= '0;
        else if (state_next != state)  cnt <= '0;
        else if (state == S_HOLD || state == S_RUN) cnt <= cnt + 1'b1;
    end

    // Index walks 0..N_REGS-1 only inside CHECK and is zero everywhere else.
    always_ff @(posedge clk) begin
        if (rst)                                   idx <= '0;
        else if (state == S_CHECK && idx != LAST_IDX) idx <= idx + 1'b1;
        else                                       idx <= '0;
    end

    // NOTE: fail_map is a small flag register, not a RAM, so it is cleared by reset with the other results.
    always_ff @(posedge clk) begin
        if (rst || take_start) begin
            fail_count <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
`ifdef MIPS_RUN_CHECKER_FAILMAP_EN
            fail_map   <= '0;
`endif
        end else begin
            if (mismatch) begin
                if (fail_count != MAX_FAILS) fail_count <= fail_count + 1'b1;
                if (fail_count == '0)        first_fail <= idx;
`ifdef MIPS_RUN_CHECKER_FAILMAP_EN
                fail_map[idx] <= 1'b1;
`endif
            end
            // Verdict includes the final comparison so it is ready as done rises.
            if (state == S_CHECK && idx == LAST_IDX)
                pass <= (fail_count == '0) && !mismatch;
        end
    end

endmodule
